// File: rtl/ws2812b_rx_module.sv
// WS2812B single-wire receiver: synchronises the data line, decodes pulse widths into
// MSB-first 24-bit pixels and reports frame latch gaps and protocol errors.
module ws2812b_rx_module #(
   parameter int unsigned CYCLES_THRESHOLD = 6,
   parameter int unsigned CYCLES_MAX_HIGH  = 32,
   parameter int unsigned CYCLES_RET       = 270,
   parameter int unsigned INDEX_WIDTH      = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ws2812b_in,
   output logic [23:0]            pixel_data,
   output logic                   pixel_valid,
   output logic [INDEX_WIDTH-1:0] pixel_index,
   output logic                   frame_done,
   output logic [INDEX_WIDTH-1:0] frame_pixels,
   output logic                   error,
   output logic [1:0]             error_code
);

   localparam int unsigned CntMax = (CYCLES_RET > CYCLES_MAX_HIGH) ? CYCLES_RET : CYCLES_MAX_HIGH;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   typedef enum logic [1:0] {StWaitGap, StIdle, StHigh, StLow} state_e;

   state_e                 state_q, state_d;
   logic                   s1_q, s2_q;
   logic [CntW-1:0]        high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
   logic [CntW-1:0]        high_inc, low_inc;
   logic [4:0]             bit_cnt_q, bit_cnt_d;
   logic [INDEX_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
   logic [23:0]            shift_q, shift_d;
   logic [23:0]            pixel_data_q, pixel_data_d;
   logic [INDEX_WIDTH-1:0] pixel_index_q, pixel_index_d;
   logic [INDEX_WIDTH-1:0] frame_pixels_q, frame_pixels_d;
   logic                   pixel_valid_q, pixel_valid_d;
   logic                   frame_done_q, frame_done_d;
   logic                   error_q, error_d;
   logic [1:0]             error_code_q, error_code_d;
   logic                   bit_val;

   assign high_inc = (high_cnt_q == {CntW{1'b1}}) ? high_cnt_q : high_cnt_q + CntW'(1);
   assign low_inc  = (low_cnt_q == {CntW{1'b1}}) ? low_cnt_q : low_cnt_q + CntW'(1);
   assign bit_val  = (high_cnt_q >= CntW'(CYCLES_THRESHOLD));

   always_comb begin
      state_d        = state_q;
      high_cnt_d     = high_cnt_q;
      low_cnt_d      = low_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      pix_cnt_d      = pix_cnt_q;
      shift_d        = shift_q;
      pixel_data_d   = pixel_data_q;
      pixel_index_d  = pixel_index_q;
      frame_pixels_d = frame_pixels_q;
      error_code_d   = error_code_q;
      pixel_valid_d  = 1'b0;
      frame_done_d   = 1'b0;
      error_d        = 1'b0;
      unique case (state_q)
         StWaitGap: begin
            if (s2_q) begin
               low_cnt_d = '0;
            end else begin
               low_cnt_d = low_inc;
               if (low_inc == CntW'(CYCLES_RET)) state_d = StIdle;
            end
         end
         StIdle: begin
            if (s2_q) begin
               state_d    = StHigh;
               high_cnt_d = CntW'(1);
               bit_cnt_d  = '0;
               pix_cnt_d  = '0;
               shift_d    = '0;
            end
         end
         StHigh: begin
            if (s2_q) begin
               high_cnt_d = high_inc;
               if (high_inc == CntW'(CYCLES_MAX_HIGH)) begin
                  // Stuck-high line: abandon the frame and resynchronise on a full gap.
                  error_d      = 1'b1;
                  error_code_d = 2'd1;
                  shift_d      = '0;
                  bit_cnt_d    = '0;
                  pix_cnt_d    = '0;
                  high_cnt_d   = '0;
                  low_cnt_d    = '0;
                  state_d      = StWaitGap;
               end
            end else begin
               shift_d   = {shift_q[22:0], bit_val};
               low_cnt_d = CntW'(1);
               state_d   = StLow;
               if (bit_cnt_q == 5'd23) begin
                  pixel_data_d  = {shift_q[22:0], bit_val};
                  pixel_index_d = pix_cnt_q;
                  pixel_valid_d = 1'b1;
                  pix_cnt_d     = pix_cnt_q + INDEX_WIDTH'(1);
                  bit_cnt_d     = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
         StLow: begin
            if (s2_q) begin
               state_d    = StHigh;
               high_cnt_d = CntW'(1);
            end else begin
               low_cnt_d = low_inc;
               if (low_inc == CntW'(CYCLES_RET)) begin
                  frame_done_d   = 1'b1;
                  frame_pixels_d = pix_cnt_q;
                  if (bit_cnt_q != 5'd0) begin
                     error_d      = 1'b1;
                     error_code_d = 2'd2;
                  end
                  bit_cnt_d = '0;
                  shift_d   = '0;
                  state_d   = StIdle;
               end
            end
         end
         default: state_d = StWaitGap;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StWaitGap;
         s1_q           <= 1'b0;
         s2_q           <= 1'b0;
         high_cnt_q     <= '0;
         low_cnt_q      <= '0;
         bit_cnt_q      <= '0;
         pix_cnt_q      <= '0;
         shift_q        <= '0;
         pixel_data_q   <= '0;
         pixel_index_q  <= '0;
         frame_pixels_q <= '0;
         pixel_valid_q  <= 1'b0;
         frame_done_q   <= 1'b0;
         error_q        <= 1'b0;
         error_code_q   <= '0;
      end else begin
         state_q        <= state_d;
         s1_q           <= ws2812b_in;
         s2_q           <= s1_q;
         high_cnt_q     <= high_cnt_d;
         low_cnt_q      <= low_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         pix_cnt_q      <= pix_cnt_d;
         shift_q        <= shift_d;
         pixel_data_q   <= pixel_data_d;
         pixel_index_q  <= pixel_index_d;
         frame_pixels_q <= frame_pixels_d;
         pixel_valid_q  <= pixel_valid_d;
         frame_done_q   <= frame_done_d;
         error_q        <= error_d;
         error_code_q   <= error_code_d;
      end
   end

   assign pixel_data   = pixel_data_q;
   assign pixel_valid  = pixel_valid_q;
   assign pixel_index  = pixel_index_q;
   assign frame_done   = frame_done_q;
   assign frame_pixels = frame_pixels_q;
   assign error        = error_q;
   assign error_code   = error_code_q;

endmodule

// File: tb/tb_ws2812b_rx_module.sv
// Scoreboard bench for ws2812b_rx_module: stimulus pushes expected strobes into queues,
// a negedge monitor pops and compares them as the DUT raises each strobe.
module tb_ws2812b_rx_module;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ws = 1'b0;
   logic [23:0] pixel_data;
   logic        pixel_valid;
   logic [9:0]  pixel_index;
   logic        frame_done;
   logic [9:0]  frame_pixels;
   logic        error;
   logic [1:0]  error_code;

   int checks = 0;
   int failures = 0;

   logic [33:0] exp_pix[$];
   int          exp_frame[$];
   logic [1:0]  exp_err[$];
   logic [33:0] e_pix;
   int          e_frame;
   logic [1:0]  e_err;

   ws2812b_rx_module dut (
      .clk          (clk),
      .reset        (reset),
      .ws2812b_in   (ws),
      .pixel_data   (pixel_data),
      .pixel_valid  (pixel_valid),
      .pixel_index  (pixel_index),
      .frame_done   (frame_done),
      .frame_pixels (frame_pixels),
      .error        (error),
      .error_code   (error_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic hold(input logic v, input int n);
      ws = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      if (b) begin hold(1'b1, 8); hold(1'b0, 4); end
      else begin hold(1'b1, 4); hold(1'b0, 8); end
   endtask

   task automatic send_word(input logic [23:0] w, input int nbits);
      for (int i = 23; i > 23 - nbits; i--) send_bit(w[i]);
   endtask

   task automatic expect_pixel(input logic [23:0] d, input int idx);
      exp_pix.push_back({10'(idx), d});
   endtask

   task automatic check_reset_values();
      check("rst_pixel_data", 34'(pixel_data), 34'd0);
      check("rst_pixel_valid", 34'(pixel_valid), 34'd0);
      check("rst_pixel_index", 34'(pixel_index), 34'd0);
      check("rst_frame_done", 34'(frame_done), 34'd0);
      check("rst_frame_pixels", 34'(frame_pixels), 34'd0);
      check("rst_error", 34'(error), 34'd0);
      check("rst_error_code", 34'(error_code), 34'd0);
   endtask

   always @(negedge clk) begin
      if (pixel_valid) begin
         if (exp_pix.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_pixel: got idx=%0d data=%h required no strobe",
                     pixel_index, pixel_data);
         end else begin
            e_pix = exp_pix.pop_front();
            check("pixel_data", 34'(pixel_data), 34'(e_pix[23:0]));
            check("pixel_index", 34'(pixel_index), 34'(e_pix[33:24]));
         end
         check("strobe_overlap", 34'({frame_done, error}), 34'd0);
      end
      if (frame_done) begin
         if (exp_frame.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_frame_done: got frame_pixels=%0d required no strobe",
                     frame_pixels);
         end else begin
            e_frame = exp_frame.pop_front();
            check("frame_pixels", 34'(frame_pixels), 34'(e_frame));
         end
      end
      if (error) begin
         if (exp_err.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_error: got code=%0d required no strobe", error_code);
         end else begin
            e_err = exp_err.pop_front();
            check("error_code", 34'(error_code), 34'(e_err));
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check_reset_values();
      reset = 1'b0;
      @(negedge clk);
      check_reset_values();

      // Single pixel after initial gap
      hold(1'b0, 280);
      expect_pixel(24'hA5C30F, 0);
      send_word(24'hA5C30F, 24);
      exp_frame.push_back(1);
      hold(1'b0, 300);

      // Three pixels, then a second frame restarting at index 0
      expect_pixel(24'hFF0000, 0);
      expect_pixel(24'h00FF00, 1);
      expect_pixel(24'h0000FF, 2);
      send_word(24'hFF0000, 24);
      send_word(24'h00FF00, 24);
      send_word(24'h0000FF, 24);
      exp_frame.push_back(3);
      hold(1'b0, 300);
      expect_pixel(24'h123456, 0);
      send_word(24'h123456, 24);
      exp_frame.push_back(1);
      hold(1'b0, 300);

      // Threshold boundary: 5-sample high is 0, 6-sample high is 1
      expect_pixel(24'h555555, 0);
      for (int i = 0; i < 24; i++) begin
         hold(1'b1, (i % 2 == 0) ? 5 : 6);
         hold(1'b0, 4);
      end
      exp_frame.push_back(1);
      hold(1'b0, 300);

      // Stuck-high line mid-pixel, then recovery
      send_word(24'hABCDEF, 10);
      exp_err.push_back(2'd1);
      hold(1'b1, 40);
      hold(1'b0, 300);
      check("error_code_held", 34'(error_code), 34'd1);
      expect_pixel(24'h0F0F0F, 0);
      send_word(24'h0F0F0F, 24);
      exp_frame.push_back(1);
      hold(1'b0, 300);

      // Partial pixel at latch
      send_word(24'hABC000, 12);
      exp_frame.push_back(0);
      exp_err.push_back(2'd2);
      hold(1'b0, 300);
      check("error_code_held2", 34'(error_code), 34'd2);

      // Pixels arriving before the initial gap are ignored
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      send_word(24'h765432, 24);
      hold(1'b0, 300);
      expect_pixel(24'hC0FFEE, 0);
      send_word(24'hC0FFEE, 24);
      exp_frame.push_back(1);
      hold(1'b0, 300);

      // Reset mid-frame
      expect_pixel(24'h111111, 0);
      send_word(24'h111111, 24);
      send_word(24'h333333, 8);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_values();
      reset = 1'b0;
      send_word(24'h333333, 16);
      send_word(24'h444444, 24);
      hold(1'b0, 300);
      expect_pixel(24'h222222, 0);
      send_word(24'h222222, 24);
      exp_frame.push_back(1);
      hold(1'b0, 300);

      check("pixels_outstanding", 34'(exp_pix.size()), 34'd0);
      check("frames_outstanding", 34'(exp_frame.size()), 34'd0);
      check("errors_outstanding", 34'(exp_err.size()), 34'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
